// File: rtl/cli_mux_operand_parser.sv
// Line parser for "<sel> <op0> <op1>\r" commands feeding MUX_2; registers SEL/IN_0/IN_1
// only on a complete valid line and pulses ERR for one cycle on a rejected line.
module cli_mux_operand_parser (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  CHR_IN,
    input  logic        CHR_VALID,
    output logic        CHR_READY,
    output logic        SEL,
    output logic [31:0] IN_0,
    output logic [31:0] IN_1,
    output logic        OP_VALID,
    input  logic        OP_ACK,
    output logic        ERR
);
    localparam logic [7:0] SEP_CHR  = 8'h20;
    localparam logic [7:0] TERM_CHR = 8'h0D;

    typedef enum logic [2:0] {
        S_SEL   = 3'd0,
        S_GAP1  = 3'd1,
        S_GAP2  = 3'd2,
        S_OP0   = 3'd3,
        S_OP1   = 3'd4,
        S_TAIL  = 3'd5,
        S_DONE  = 3'd6,
        S_DRAIN = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic        sel_sh_q, sel_sh_d;
    logic [31:0] op0_sh_q, op0_sh_d;
    logic [31:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic        gap_seen_q, gap_seen_d;
    logic        sel_q, sel_d;
    logic [31:0] in0_q, in0_d;
    logic [31:0] in1_q, in1_d;
    logic        op_valid_q, op_valid_d;
    logic        err_q, err_d;

    logic        accept_s;
    logic        is_digit_s;
    logic        is_sep_s;
    logic        is_term_s;
    logic [35:0] acc_mul_s;

    assign CHR_READY  = RST_N && (state_q != S_DONE);
    assign accept_s   = CHR_VALID && CHR_READY;
    assign is_digit_s = (CHR_IN >= 8'h30) && (CHR_IN <= 8'h39);
    assign is_sep_s   = (CHR_IN == SEP_CHR);
    assign is_term_s  = (CHR_IN == TERM_CHR);
    // Wide accumulate so a carry past bit 31 is visible as overflow.
    assign acc_mul_s  = ({4'd0, acc_q} * 36'd10) + {32'd0, CHR_IN[3:0]};

    // Next-state and datapath update for one accepted character or an acknowledge.
    always_comb begin
        state_d    = state_q;
        sel_sh_d   = sel_sh_q;
        op0_sh_d   = op0_sh_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        gap_seen_d = gap_seen_q;
        sel_d      = sel_q;
        in0_d      = in0_q;
        in1_d      = in1_q;
        op_valid_d = op_valid_q;
        err_d      = 1'b0;

        if (state_q == S_DONE) begin
            if (OP_ACK) begin
                op_valid_d = 1'b0;
                state_d    = S_SEL;
            end else begin
                state_d    = S_DONE;
            end
        end else if (accept_s) begin
            case (state_q)
                S_SEL: begin
                    if (is_sep_s || is_term_s) begin
                        state_d = S_SEL;
                    end else if ((CHR_IN == 8'h30) || (CHR_IN == 8'h31)) begin
                        sel_sh_d   = CHR_IN[0];
                        gap_seen_d = 1'b0;
                        state_d    = S_GAP1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_GAP1, S_GAP2: begin
                    if (is_sep_s) begin
                        gap_seen_d = 1'b1;
                    end else if (is_digit_s && gap_seen_q) begin
                        acc_d   = {28'd0, CHR_IN[3:0]};
                        ovf_d   = 1'b0;
                        state_d = (state_q == S_GAP1) ? S_OP0 : S_OP1;
                    end else if (is_term_s) begin
                        err_d   = 1'b1;
                        state_d = S_SEL;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_OP0, S_OP1: begin
                    if (is_digit_s) begin
                        acc_d = acc_mul_s[31:0];
                        ovf_d = ovf_q | (|acc_mul_s[35:32]);
                    end else if (is_sep_s && ovf_q) begin
                        state_d = S_DRAIN;
                    end else if (is_sep_s && (state_q == S_OP0)) begin
                        op0_sh_d   = acc_q;
                        gap_seen_d = 1'b1;
                        state_d    = S_GAP2;
                    end else if (is_sep_s) begin
                        state_d = S_TAIL;
                    end else if (is_term_s && (state_q == S_OP1) && !ovf_q) begin
                        sel_d      = sel_sh_q;
                        in0_d      = op0_sh_q;
                        in1_d      = acc_q;
                        op_valid_d = 1'b1;
                        state_d    = S_DONE;
                    end else if (is_term_s) begin
                        err_d   = 1'b1;
                        state_d = S_SEL;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_TAIL: begin
                    if (is_sep_s) begin
                        state_d = S_TAIL;
                    end else if (is_term_s) begin
                        sel_d      = sel_sh_q;
                        in0_d      = op0_sh_q;
                        in1_d      = acc_q;
                        op_valid_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (is_term_s) begin
                        err_d   = 1'b1;
                        state_d = S_SEL;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: begin
                    state_d = S_SEL;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_SEL;
            sel_sh_q   <= 1'b0;
            op0_sh_q   <= 32'd0;
            acc_q      <= 32'd0;
            ovf_q      <= 1'b0;
            gap_seen_q <= 1'b0;
            sel_q      <= 1'b0;
            in0_q      <= 32'd0;
            in1_q      <= 32'd0;
            op_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_sh_q   <= sel_sh_d;
            op0_sh_q   <= op0_sh_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            gap_seen_q <= gap_seen_d;
            sel_q      <= sel_d;
            in0_q      <= in0_d;
            in1_q      <= in1_d;
            op_valid_q <= op_valid_d;
            err_q      <= err_d;
        end
    end

    assign SEL      = sel_q;
    assign IN_0     = in0_q;
    assign IN_1     = in1_q;
    assign OP_VALID = op_valid_q;
    assign ERR      = err_q;
endmodule
